// File: rtl/crc_spi_tx_master.sv
`default_nettype none
// ============================================================================
// Module   : crc_spi_tx_master
// Function : Accepts a 24-bit payload, appends CRC8 (poly 0x2F), and shifts the
//            32-bit frame out MSB-first on an SPI mode-0 master port.
// Revision : 1.0  initial release
// ============================================================================
module crc_spi_tx_master #(
    parameter int LEN_DATA   = 24,
    parameter int LEN_CRC    = 8,
    parameter int LEN_PACKET = 32,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_DATA-1:0]   tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [LEN_CRC-1:0]    crc_out,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_sdo
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int BIT_W = $clog2(LEN_PACKET);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LEN_PACKET - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CRC   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                  state;
    logic [LEN_DATA-1:0]     data_reg;
    logic [LEN_PACKET-1:0]   shreg;
    logic [DIV_W-1:0]        div_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [LEN_CRC-1:0]      crc_calc;

    // Serial CRC unrolled over the latched payload, MSB processed first.
    function automatic logic [LEN_CRC-1:0] crc8(input logic [LEN_DATA-1:0] d);
        logic [LEN_CRC-1:0] c;
        logic               fb;
        c = '0;
        for (int i = LEN_DATA - 1; i >= 0; i--) begin
            fb = c[LEN_CRC-1] ^ d[i];
            c  = {c[LEN_CRC-2:0], 1'b0} ^ (fb ? 8'h2F : 8'h00);
        end
        return c;
    endfunction

    assign crc_calc = crc8(data_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= '0;
            shreg    <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            crc_out  <= '0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_reg <= tx_data;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= CRC;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                CRC: begin
                    shreg    <= {data_reg, crc_calc};
                    crc_out  <= crc_calc;
                    spi_cs_n <= 1'b0;
                    spi_sdo  <= data_reg[LEN_DATA-1];
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        // Data only moves on the falling sclk edge (mode 0).
                        if (spi_sclk) begin
                            if (bit_cnt == BIT_LAST) begin
                                spi_cs_n <= 1'b1;
                                spi_sdo  <= 1'b0;
                                tx_done  <= 1'b1;
                                gap_cnt  <= '0;
                                state    <= GAP;
                            end else begin
                                shreg   <= {shreg[LEN_PACKET-2:0], 1'b0};
                                spi_sdo <= shreg[LEN_PACKET-2];
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_busy  <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_spi_tx_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_spi_tx_master
// Function : Scoreboard bench; an SPI receiver model checks each frame against
//            a polynomial-division CRC reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_crc_spi_tx_master;

    localparam int D = 2;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_busy, tx_done;
    logic [7:0]  crc_out;
    logic        spi_cs_n, spi_sclk, spi_sdo;

    crc_spi_tx_master #(
        .LEN_DATA(24), .LEN_CRC(8), .LEN_PACKET(32), .CLK_DIV(D), .CS_GAP(G)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .crc_out(crc_out), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_sdo(spi_sdo)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    // CRC as remainder of (data * x^8) divided by x^8+x^5+x^3+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [23:0] d);
        logic [31:0] r;
        logic [31:0] poly;
        r    = {d, 8'h00};
        poly = 32'h12F;
        for (int i = 31; i >= 8; i--)
            if (r[i]) r = r ^ (poly << (i - 8));
        return r[7:0];
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitor: SPI receiver + scoreboard ----------------
    logic [31:0] mon_shift;
    int          mon_bits, toggles, cs_low, gap_hi;
    logic        prev_sclk, prev_cs, seen_frame;
    logic [31:0] expf;

    initial begin
        mon_shift = '0; mon_bits = 0; toggles = 0; cs_low = 0; gap_hi = 0;
        prev_sclk = 1'b0; prev_cs = 1'b1; seen_frame = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            mon_shift = '0; mon_bits = 0; toggles = 0; cs_low = 0; gap_hi = 0;
            prev_sclk = 1'b0; prev_cs = 1'b1; seen_frame = 1'b0;
        end else begin
            check("ready_busy_exclusive", 32'(tx_ready & tx_busy), 32'd0);
            check("sclk_idle_when_cs_high", 32'(spi_sclk & spi_cs_n), 32'd0);
            if (spi_sclk && !prev_sclk) begin
                mon_shift = {mon_shift[30:0], spi_sdo};
                mon_bits++;
            end
            if (spi_sclk != prev_sclk) toggles++;
            if (!spi_cs_n) cs_low++;
            else gap_hi++;
            if (!spi_cs_n && prev_cs && seen_frame)
                check("cs_gap_ge_CS_GAP", 32'(gap_hi >= G), 32'd1);
            if (tx_done) begin
                check("cs_n_high_at_done", 32'(spi_cs_n), 32'd1);
                check("sdo_low_at_done", 32'(spi_sdo), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_done", 32'd1, 32'd0);
                end else begin
                    expf = exp_q.pop_front();
                    check("frame", mon_shift, expf);
                    check("crc_out", 32'(crc_out), 32'(expf[7:0]));
                    check("rising_edges", 32'(mon_bits), 32'd32);
                    check("sclk_toggles", 32'(toggles), 32'd64);
                    check("cs_low_cycles", 32'(cs_low), 32'(64 * D));
                end
                mon_shift = '0; mon_bits = 0; toggles = 0; cs_low = 0;
                gap_hi = 0; seen_frame = 1'b1;
            end
            prev_sclk = spi_sclk;
            prev_cs   = spi_cs_n;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [23:0] d, output logic acc);
        @(negedge clk);
        tx_valid = v;
        tx_data  = d;
        #1;
        acc = v && tx_ready && !rst;
        if (acc) exp_q.push_back({d, ref_crc(d)});
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0, a);
    endtask

    task automatic send(input logic [23:0] d);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 2000) begin
            drive(1'b1, d, a);
            n++;
        end
        if (!a) check("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            idle(1);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    task automatic busy_pulse(input int delay);
        logic a;
        idle(delay);
        drive(1'b1, 24'($urandom), a);
        check("busy_pulse_ignored", 32'(a), 32'd0);
    endtask

    initial begin
        logic [23:0] rd;
        int          n;

        repeat (3) @(negedge clk);
        check("ready_low_in_reset", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_sdo", 32'(spi_sdo), 32'd0);
        check("rst_crc_out", 32'(crc_out), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        idle(20);

        send(24'h000001); drain();
        send(24'h800000); send(24'h000080); drain();
        send(24'h000000); drain();
        send(24'h123456); busy_pulse(10); drain();

        for (int i = 0; i < 10; i++) begin
            rd = 24'($urandom);
            send(rd);
            if ($urandom_range(0, 1) == 1) busy_pulse($urandom_range(0, 100));
            idle($urandom_range(0, 5));
        end
        drain();

        // Reset in the middle of a frame, then recover.
        send(24'hA5C3F0);
        n = 0;
        while (mon_bits < 10 && n < 1000) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reach_bit10", 32'(mon_bits >= 10), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        check("midrst_sclk", 32'(spi_sclk), 32'd0);
        check("midrst_sdo", 32'(spi_sdo), 32'd0);
        check("midrst_done", 32'(tx_done), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(10);
        send(24'h5A5A5A); drain();
        send(24'($urandom)); drain();

        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
